// File: rtl/memory_arbiter_pkg.sv
// Shared types for the two-port (I$/D$) memory arbiter: FSM encoding, grant IDs
// and default widths.
package memory_arbiter_pkg;
  localparam int ADDR_W_DEF  = 28;
  localparam int BLOCK_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } grant_e;
endpackage

// File: rtl/memory_arbiter_rr_select.sv
// Two-way round-robin pick: on a tie the requester that did not win last time
// gets the grant; a lone requester always wins.
module rr_select
  import memory_arbiter_pkg::*;
(
  input  logic   i_req_i,
  input  logic   d_req_i,
  input  grant_e last_grant_i,
  output grant_e grant_o,
  output logic   valid_o
);
  always_comb begin
    valid_o = i_req_i | d_req_i;
    grant_o = ICACHE;
    if (i_req_i && d_req_i) grant_o = (last_grant_i == ICACHE) ? DCACHE : ICACHE;
    else if (d_req_i)       grant_o = DCACHE;
  end
endmodule

// File: rtl/memory_arbiter.sv
// Shares one main-memory port between the instruction and data caches.
// IDLE latches the winner's request, ISSUE presents it, WAIT holds it until memory finishes.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int BLOCK_W = BLOCK_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               i_read,
  input  logic [ADDR_W-1:0]  i_address,
  output logic [BLOCK_W-1:0] i_readdata,
  output logic               i_busywait,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_address,
  input  logic [BLOCK_W-1:0] d_writedata,
  output logic [BLOCK_W-1:0] d_readdata,
  output logic               d_busywait,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait,
  output logic               mem_timeout
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_e               state_q, state_d;
  grant_e               grant_q, last_grant_q, sel_grant;
  logic                 sel_valid, complete, i_req, d_req;
  logic                 done_q, busy_seen_q, timeout_q, mem_read_q, mem_write_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [BLOCK_W-1:0]   wdata_q, i_rdata_q, d_rdata_q;
  logic [CNT_W-1:0]     cnt_q;

  // The requester served last cycle still holds its request while it sees
  // busywait low; mask it so the same block is not fetched twice.
  assign i_req = i_read & ~(done_q & (grant_q == ICACHE));
  assign d_req = (d_read | d_write) & ~(done_q & (grant_q == DCACHE));

  rr_select u_rr (
    .i_req_i      (i_req),
    .d_req_i      (d_req),
    .last_grant_i (last_grant_q),
    .grant_o      (sel_grant),
    .valid_o      (sel_valid)
  );

  assign complete = (state_q == WAIT) && !mem_busywait && busy_seen_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sel_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (complete) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= IDLE;
      grant_q      <= ICACHE;
      last_grant_q <= DCACHE;
      done_q       <= 1'b0;
      busy_seen_q  <= 1'b0;
      timeout_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      cnt_q        <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= complete;
      if (state_q == IDLE && sel_valid) begin
        grant_q     <= sel_grant;
        addr_q      <= (sel_grant == ICACHE) ? i_address : d_address;
        if (sel_grant == DCACHE) wdata_q <= d_writedata;
        // read+write together from the D$ is a write-back
        mem_write_q <= (sel_grant == DCACHE) && d_write;
        mem_read_q  <= !((sel_grant == DCACHE) && d_write);
        busy_seen_q <= 1'b0;
        cnt_q       <= '0;
      end
      if ((state_q == ISSUE || state_q == WAIT) && mem_busywait) busy_seen_q <= 1'b1;
      if (state_q == WAIT) begin
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CNT_MAX - 1'b1) timeout_q <= 1'b1;
      end
      if (complete) begin
        mem_read_q   <= 1'b0;
        mem_write_q  <= 1'b0;
        last_grant_q <= grant_q;
        if (mem_read_q) begin
          if (grant_q == ICACHE) i_rdata_q <= mem_readdata;
          else                   d_rdata_q <= mem_readdata;
        end
      end
    end
  end

  assign i_busywait    = i_req;
  assign d_busywait    = d_req;
  assign i_readdata    = i_rdata_q;
  assign d_readdata    = d_rdata_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = addr_q;
  assign mem_writedata = wdata_q;
  assign mem_timeout   = timeout_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench: a memory responder consumes queued transactions and a
// completion monitor checks the data each cache sees when its busywait drops.
module tb_memory_arbiter;
  localparam int AW = 28, BW = 128, TO = 8;

  logic          CLK = 1'b0, RESET = 1'b0;
  logic          i_read = 0, d_read = 0, d_write = 0;
  logic [AW-1:0] i_address = '0, d_address = '0;
  logic [BW-1:0] d_writedata = '0, mem_readdata = '0;
  logic          mem_busywait = 1'b0;
  logic [BW-1:0] i_readdata, d_readdata, mem_writedata;
  logic          i_busywait, d_busywait, mem_read, mem_write, mem_timeout;
  logic [AW-1:0] mem_address;

  always #5 CLK = ~CLK;

  memory_arbiter #(.ADDR_W(AW), .BLOCK_W(BW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait), .mem_timeout(mem_timeout)
  );

  typedef struct {
    logic          gnt;
    logic [AW-1:0] addr;
    logic          wr;
    logic [BW-1:0] wdata;
    logic [BW-1:0] rdata;
    int            busy;
  } txn_t;

  txn_t          exp_q[$], cmp_q[$];
  int            checks = 0, errors = 0, i_done = 0, d_done = 0, idle_cnt = 1, tgt = 0;
  bit            resp_active = 0;
  logic [BW-1:0] last_i = '0, last_d = '0;

  task automatic chk(string tag, logic [BW-1:0] got, logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(logic gnt, logic [AW-1:0] a, logic wr, logic [BW-1:0] wd,
                      logic [BW-1:0] rd, int busy);
    txn_t t;
    t.gnt = gnt; t.addr = a; t.wr = wr; t.wdata = wd; t.rdata = rd; t.busy = busy;
    exp_q.push_back(t);
  endtask

  task automatic wait_total(int target, int budget);
    int c = 0;
    while ((i_done + d_done) < target && c < budget) begin
      @(negedge CLK); #1; c++;
    end
    chk("done_wait", BW'((i_done + d_done) >= target), 1);
  endtask

  // memory model: busy for t.busy cycles starting in the ISSUE cycle
  initial begin : responder
    txn_t t;
    int left, nw;
    left = 0; nw = 0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        resp_active = 0; mem_busywait = 1'b0; idle_cnt = 1;
      end else if (!resp_active) begin
        if (mem_read || mem_write) begin
          chk("idle_gap", BW'(idle_cnt >= 1), 1);
          chk("txn_queued", BW'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) t = exp_q.pop_front();
          else begin t.addr = mem_address; t.wr = mem_write; t.wdata = mem_writedata; t.busy = 1; end
          chk("mem_addr", mem_address, t.addr);
          chk("mem_write", mem_write, t.wr);
          chk("mem_read", mem_read, !t.wr);
          if (t.wr) chk("mem_wdata", mem_writedata, t.wdata);
          cmp_q.push_back(t);
          left = t.busy - 1; nw = 0;
          mem_busywait = 1'b1; resp_active = 1;
        end else idle_cnt++;
      end else if (!(mem_read || mem_write)) begin
        resp_active = 0; idle_cnt = 1;
      end else begin
        nw++;
        chk("hold_addr", mem_address, t.addr);
        if (t.wr) chk("hold_wdata", mem_writedata, t.wdata);
        if (t.busy > TO + 1 && nw == TO)     chk("timeout_pre", mem_timeout, 0);
        if (t.busy > TO + 1 && nw == TO + 1) chk("timeout_set", mem_timeout, 1);
        if (left > 0) left--;
        else begin mem_busywait = 1'b0; mem_readdata = t.rdata; end
      end
    end
  end

  initial begin : monitor
    txn_t t;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        if (i_read && !i_busywait) begin
          chk("i_cmp_queued", BW'(cmp_q.size() != 0), 1);
          if (cmp_q.size() != 0) begin
            t = cmp_q.pop_front();
            chk("i_gnt", t.gnt, 0);
            chk("i_rdata", i_readdata, t.rdata);
            last_i = t.rdata;
          end
          i_done++;
        end
        if ((d_read || d_write) && !d_busywait) begin
          chk("d_cmp_queued", BW'(cmp_q.size() != 0), 1);
          if (cmp_q.size() != 0) begin
            t = cmp_q.pop_front();
            chk("d_gnt", t.gnt, 1);
            if (t.wr) chk("d_rdata_hold", d_readdata, last_d);
            else begin chk("d_rdata", d_readdata, t.rdata); last_d = t.rdata; end
          end
          d_done++;
        end
        if (!i_read)              chk("i_bw_idle", i_busywait, 0);
        if (!(d_read || d_write)) chk("d_bw_idle", d_busywait, 0);
      end
    end
  end

  initial begin
    int c;
    repeat (2) @(negedge CLK);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_address, 0);
    chk("rst_mem_wdata", mem_writedata, 0);
    chk("rst_i_rdata", i_readdata, 0);
    chk("rst_d_rdata", d_readdata, 0);
    chk("rst_timeout", mem_timeout, 0);
    #1 RESET = 1'b1;
    @(negedge CLK); #1;

    // tie right after reset: I first, then D
    push(0, 28'h0000100, 0, '0, {4{32'h1111_0000}}, 2);
    push(1, 28'h0000200, 0, '0, {4{32'h2222_0000}}, 2);
    i_address = 28'h0000100; d_address = 28'h0000200;
    i_read = 1; d_read = 1;
    tgt += 1; wait_total(tgt, 40); i_read = 0;
    tgt += 1; wait_total(tgt, 40); d_read = 0;

    // sustained contention: I, D, I, D
    i_address = 28'h0000300; d_address = 28'h0000400;
    for (int k = 0; k < 2; k++) begin
      push(0, 28'h0000300, 0, '0, {4{32'h3300_0000 + 32'(k)}}, 2);
      push(1, 28'h0000400, 0, '0, {4{32'h4400_0000 + 32'(k)}}, 2);
    end
    i_read = 1; d_read = 1;
    tgt += 4; wait_total(tgt, 80); i_read = 0; d_read = 0;

    // lone read, memory busy 5 cycles
    push(0, 28'h0000010, 0, '0, {16{8'hA5}}, 5);
    i_address = 28'h0000010; i_read = 1;
    tgt += 1; wait_total(tgt, 40); i_read = 0;

    // write-back (read+write together), inputs scrambled mid-flight
    push(1, 28'h0ABCDEF, 1, 128'h1234, {4{32'hDEAD_BEEF}}, 4);
    d_address = 28'h0ABCDEF; d_writedata = 128'h1234; d_write = 1; d_read = 1;
    repeat (3) @(negedge CLK);
    #1 d_address = 28'h0000001; d_writedata = '1;
    tgt += 1; wait_total(tgt, 40); d_write = 0; d_read = 0;

    // reset in WAIT abandons the transaction; pending D$ read restarts
    push(1, 28'h0000500, 0, '0, {4{32'h0BAD_0BAD}}, 6);
    d_address = 28'h0000500; d_read = 1;
    c = 0;
    while (!resp_active && c < 20) begin @(negedge CLK); #1; c++; end
    repeat (2) @(negedge CLK);
    #1 RESET = 1'b0;
    #1;
    chk("mid_rst_mem_read", mem_read, 0);
    chk("mid_rst_mem_addr", mem_address, 0);
    chk("mid_rst_i_rdata", i_readdata, 0);
    chk("mid_rst_d_rdata", d_readdata, 0);
    last_i = '0; last_d = '0;
    exp_q.delete(); cmp_q.delete();
    repeat (2) @(negedge CLK);
    #1 push(1, 28'h0000500, 0, '0, {4{32'h5555_AAAA}}, 3);
    RESET = 1'b1;
    tgt += 1; wait_total(tgt, 40); d_read = 0;

    // timeout: busy well past TIMEOUT, completes normally, flag sticks
    chk("timeout_clear", mem_timeout, 0);
    push(0, 28'h0000600, 0, '0, {16{8'hC3}}, 12);
    i_address = 28'h0000600; i_read = 1;
    tgt += 1; wait_total(tgt, 60); i_read = 0;
    chk("timeout_after", mem_timeout, 1);
    push(1, 28'h0000700, 0, '0, {4{32'h7777_0000}}, 2);
    d_address = 28'h0000700; d_read = 1;
    tgt += 1; wait_total(tgt, 40); d_read = 0;
    chk("timeout_sticky", mem_timeout, 1);

    repeat (3) @(negedge CLK);
    chk("sb_empty", BW'(exp_q.size() + cmp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
